// File: rtl/if_prefetch_queue_if.sv
// Bundle of the fetch-front-end signals: branch redirect, ID-stage drain, imem handshake and queue status.
// The master modport is the prefetch queue itself; the slave modport is its environment (memory + ID stage).
interface if_prefetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                     PCSrc;
    logic [31:0]              PC_branch;
    logic                     IF_ID_write;
    logic                     imem_req;
    logic [31:0]              imem_addr;
    logic                     imem_ack;
    logic [31:0]              imem_rdata;
    logic                     out_valid;
    logic [31:0]              out_pc;
    logic [31:0]              out_instr;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic [15:0]              flush_count;

    modport master (
        input  PCSrc, PC_branch, IF_ID_write, imem_ack, imem_rdata,
        output imem_req, imem_addr, out_valid, out_pc, out_instr, fifo_count, flush_count
    );

    modport slave (
        output PCSrc, PC_branch, IF_ID_write, imem_ack, imem_rdata,
        input  imem_req, imem_addr, out_valid, out_pc, out_instr, fifo_count, flush_count
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: single-outstanding imem fetcher feeding a DEPTH-entry {PC, instr} FIFO.
// Optional discarded-entry statistics are built when PREFETCH_STATS_EN is defined.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    if_prefetch_queue_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_r;
    logic            req_r;
    logic [31:0]     addr_r;
    logic [31:0]     fetch_pc_r;
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [CW-1:0]   count_r;
    logic [31:0]     pc_mem_r    [DEPTH];
    logic [31:0]     instr_mem_r [DEPTH];

    logic            full_s;
    logic            push_s;
    logic            pop_s;

    // Per-cycle FIFO strobes; a redirect suppresses both push and pop.
    always_comb begin
        full_s = (count_r == CW'(DEPTH));
        if (state_r == WAIT && bus.imem_ack && !bus.PCSrc) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (count_r != {CW{1'b0}} && bus.IF_ID_write && !bus.PCSrc) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Fetch FSM; req/addr are registered and only change on issue or ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            req_r      <= 1'b0;
            addr_r     <= RESET_PC;
            fetch_pc_r <= RESET_PC;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.PCSrc) begin
                        fetch_pc_r <= bus.PC_branch;
                        req_r      <= 1'b0;
                    end else if (!full_s) begin
                        req_r   <= 1'b1;
                        addr_r  <= fetch_pc_r;
                        state_r <= WAIT;
                    end else begin
                        req_r <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        req_r   <= 1'b0;
                        state_r <= IDLE;
                        if (bus.PCSrc) begin
                            fetch_pc_r <= bus.PC_branch;
                        end else begin
                            fetch_pc_r <= fetch_pc_r + 32'd4;
                        end
                    end else if (bus.PCSrc) begin
                        fetch_pc_r <= bus.PC_branch;
                        state_r    <= DROP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DROP: begin
                    // The memory must see req held until it answers, even though the data is unwanted.
                    if (bus.PCSrc) begin
                        fetch_pc_r <= bus.PC_branch;
                    end else begin
                        fetch_pc_r <= fetch_pc_r;
                    end
                    if (bus.imem_ack) begin
                        req_r   <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DROP;
                    end
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk) begin
        if (reset || bus.PCSrc) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PW'(1);
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[tail_r]    <= addr_r;
            instr_mem_r[tail_r] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req   = req_r;
    assign bus.imem_addr  = addr_r;
    assign bus.out_valid  = (count_r != {CW{1'b0}});
    assign bus.out_pc     = (count_r != {CW{1'b0}}) ? pc_mem_r[head_r]    : 32'h0000_0000;
    assign bus.out_instr  = (count_r != {CW{1'b0}}) ? instr_mem_r[head_r] : 32'h0000_0000;
    assign bus.fifo_count = count_r;

`ifdef PREFETCH_STATS_EN
    logic        ack_drop_s;
    logic [15:0] discard_s;
    logic [15:0] flush_cnt_r;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Entries lost this cycle: queued entries on a redirect plus any in-flight word being thrown away.
    always_comb begin
        if (bus.imem_ack && ((state_r == WAIT && bus.PCSrc) || state_r == DROP)) begin
            ack_drop_s = 1'b1;
        end else begin
            ack_drop_s = 1'b0;
        end
        if (bus.PCSrc) begin
            discard_s = 16'(count_r) + 16'(ack_drop_s);
        end else begin
            discard_s = 16'(ack_drop_s);
        end
    end

    // Saturating discarded-entry counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_r <= 16'h0000;
        end else begin
            flush_cnt_r <= sat_add16(flush_cnt_r, discard_s);
        end
    end

    assign bus.flush_count = flush_cnt_r;
`else
    assign bus.flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: transaction-level reference model plus directed and random stimulus.
module tb_if_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_STATS_EN
    localparam logic [15:0] FLUSH_AFTER_D = 16'd3;
`else
    localparam logic [15:0] FLUSH_AFTER_D = 16'd0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    if_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // memory responder controls
    int          fixed_delay = 0;
    bit          ack_manual  = 1'b0;
    bit          man_ack     = 1'b0;
    logic [31:0] man_rdata   = 32'h0;

    // reference model state
    logic [63:0] exp_q[$];
    logic [31:0] pc_m;
    logic [31:0] addr_exp;
    bit          req_exp;
    bit          outstanding;
    bit          live;
    bit          model_on = 1'b0;
    int unsigned flush_m;

    logic [31:0] got[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_flush();
`ifdef PREFETCH_STATS_EN
        return flush_m[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_step();
        int          discard;
        int          sz;
        bit          do_push;
        logic [63:0] push_val;
        if (reset) begin
            exp_q.delete();
            pc_m = RESET_PC; addr_exp = RESET_PC;
            req_exp = 1'b0; outstanding = 1'b0; live = 1'b0; flush_m = 0;
            model_on = 1'b1;
            return;
        end
        discard = 0; sz = exp_q.size(); do_push = 1'b0; push_val = 64'h0;
        if (outstanding) begin
            if (bus.imem_ack) begin
                if (live && !bus.PCSrc) begin
                    do_push = 1'b1; push_val = {addr_exp, bus.imem_rdata}; pc_m = pc_m + 32'd4;
                end else begin
                    discard++;
                end
                outstanding = 1'b0; req_exp = 1'b0;
            end else if (bus.PCSrc) begin
                live = 1'b0;
            end
        end else if (sz < DEPTH && !bus.PCSrc) begin
            outstanding = 1'b1; live = 1'b1; req_exp = 1'b1; addr_exp = pc_m;
        end
        if (bus.PCSrc) begin
            discard += sz; exp_q.delete(); pc_m = bus.PC_branch;
        end else begin
            if (sz != 0 && bus.IF_ID_write) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(push_val);
        end
        flush_m = (flush_m + discard > 65535) ? 65535 : flush_m + discard;
    endtask

    // Monitor: compare DUT outputs with the model mid-cycle, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("req", 64'(bus.imem_req), 64'(req_exp));
                if (req_exp) chk("addr", 64'(bus.imem_addr), 64'(addr_exp));
                chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
                chk("fifo_count", 64'(bus.fifo_count), 64'(exp_q.size()));
                if (exp_q.size() != 0) begin
                    chk("out_pc", 64'(bus.out_pc), 64'(exp_q[0][63:32]));
                    chk("out_instr", 64'(bus.out_instr), 64'(exp_q[0][31:0]));
                end
                chk("flush_count", 64'(bus.flush_count), 64'(exp_flush()));
            end
            model_step();
        end
    end

    // Memory responder: acks an outstanding request after a fixed or random delay.
    initial begin
        int dly;
        bit pending;
        dly = 0; pending = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #3;
            if (ack_manual) begin
                bus.imem_ack = man_ack; bus.imem_rdata = man_rdata; pending = 1'b0;
            end else if (bus.imem_req) begin
                if (!pending) begin
                    pending = 1'b1;
                    dly = (fixed_delay < 0) ? int'($urandom_range(0, 3)) : fixed_delay;
                end
                if (dly == 0) begin
                    bus.imem_ack = 1'b1; bus.imem_rdata = $urandom(); pending = 1'b0;
                end else begin
                    dly--; bus.imem_ack = 1'b0;
                end
            end else begin
                bus.imem_ack = 1'b0; pending = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!bus.imem_req && n < 50) begin
            step();
            n++;
        end
        chk("req_timeout", 64'(bus.imem_req), 64'(1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        chk("rst_req", 64'(bus.imem_req), 64'(0));
        chk("rst_addr", 64'(bus.imem_addr), 64'(RESET_PC));
        chk("rst_count", 64'(bus.fifo_count), 64'(0));
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_pc", 64'(bus.out_pc), 64'(0));
        chk("rst_out_instr", 64'(bus.out_instr), 64'(0));
        chk("rst_flush_count", 64'(bus.flush_count), 64'(0));
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd;
        bus.PCSrc = 1'b0; bus.PC_branch = 32'h0; bus.IF_ID_write = 1'b0;

        // Sequential fill until full
        do_reset();
        fixed_delay = 0;
        got.delete();
        repeat (20) begin
            step();
            if (bus.imem_req) got.push_back(bus.imem_addr);
        end
        chk("fill_issues", 64'(got.size()), 64'(4));
        for (int i = 0; i < 4 && i < got.size(); i++) chk("fill_addr", 64'(got[i]), 64'(4 * i));
        chk("fill_count", 64'(bus.fifo_count), 64'(4));
        chk("full_req", 64'(bus.imem_req), 64'(0));

        // Drain, and the refill issue one cycle after the first pop
        bus.IF_ID_write = 1'b1;
        chk("drain_pc0", 64'(bus.out_pc), 64'(32'h0));
        step();
        chk("drain_pc1", 64'(bus.out_pc), 64'(32'h4));
        step();
        chk("drain_pc2", 64'(bus.out_pc), 64'(32'h8));
        chk("refill_req", 64'(bus.imem_req), 64'(1));
        chk("refill_addr", 64'(bus.imem_addr), 64'(32'h10));
        step();
        chk("drain_pc3", 64'(bus.out_pc), 64'(32'hC));
        bus.IF_ID_write = 1'b0;

        // Flush while waiting on a slow memory
        do_reset();
        fixed_delay = 3;
        wait_req();
        bus.PCSrc = 1'b1; bus.PC_branch = 32'h100;
        step();
        bus.PCSrc = 1'b0;
        chk("drop_req_held", 64'(bus.imem_req), 64'(1));
        chk("drop_addr_held", 64'(bus.imem_addr), 64'(32'h0));
        for (int n = 0; n < 20 && bus.imem_req; n++) step();
        chk("drop_done_valid", 64'(bus.out_valid), 64'(0));
        wait_req();
        chk("redirect_addr", 64'(bus.imem_addr), 64'(32'h100));
        chk("redirect_valid", 64'(bus.out_valid), 64'(0));

        // Flush coinciding with an ack and a pop
        do_reset();
        ack_manual = 1'b1;
        repeat (2) begin
            wait_req();
            man_ack = 1'b1; man_rdata = $urandom();
            step();
            man_ack = 1'b0;
        end
        wait_req();
        chk("pre_flush_count", 64'(bus.fifo_count), 64'(2));
        bus.PCSrc = 1'b1; bus.PC_branch = 32'h200; bus.IF_ID_write = 1'b1;
        man_ack = 1'b1; man_rdata = $urandom();
        step();
        bus.PCSrc = 1'b0; bus.IF_ID_write = 1'b0; man_ack = 1'b0;
        chk("flush_count_zero", 64'(bus.fifo_count), 64'(0));
        chk("flush_valid", 64'(bus.out_valid), 64'(0));
        chk("flush_stats", 64'(bus.flush_count), 64'(FLUSH_AFTER_D));
        wait_req();
        chk("flush_target", 64'(bus.imem_addr), 64'(32'h200));
        ack_manual = 1'b0;

        // Address wrap at the top of the 32-bit space
        do_reset();
        fixed_delay = 0;
        bus.IF_ID_write = 1'b1;
        bus.PCSrc = 1'b1; bus.PC_branch = 32'hFFFF_FFF8;
        step();
        bus.PCSrc = 1'b0;
        got.delete();
        for (int n = 0; n < 20 && got.size() < 3; n++) begin
            step();
            if (bus.imem_req) got.push_back(bus.imem_addr);
        end
        chk("wrap_issues", 64'(got.size()), 64'(3));
        if (got.size() > 0) chk("wrap_a0", 64'(got[0]), 64'(32'hFFFF_FFF8));
        if (got.size() > 1) chk("wrap_a1", 64'(got[1]), 64'(32'hFFFF_FFFC));
        if (got.size() > 2) chk("wrap_a2", 64'(got[2]), 64'(32'h0000_0000));

        // Reset in the middle of an outstanding request
        bus.IF_ID_write = 1'b0;
        repeat (6) step();
        fixed_delay = 3;
        wait_req();
        reset = 1'b1;
        step();
        chk("midrst_req", 64'(bus.imem_req), 64'(0));
        chk("midrst_count", 64'(bus.fifo_count), 64'(0));
        chk("midrst_addr", 64'(bus.imem_addr), 64'(RESET_PC));
        chk("midrst_flush", 64'(bus.flush_count), 64'(0));
        reset = 1'b0;

        // Randomised traffic against the model
        fixed_delay = -1;
        for (int i = 0; i < 4000; i++) begin
            step();
            reset = ($urandom_range(0, 99) == 0);
            bus.PCSrc = ($urandom_range(0, 15) == 0);
            rnd = $urandom();
            bus.PC_branch = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : (rnd & 32'hFFFF_FFFC);
            bus.IF_ID_write = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        end
        reset = 1'b0; bus.PCSrc = 1'b0; bus.IF_ID_write = 1'b1;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
